// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and coordinate type for the VGA raster timing generator.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared between the timing generator and pattern consumers.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  coord_t     x;
  coord_t     y;
  logic       next_frame;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output hsync, vsync, display_on, x, y, next_frame, frame_count
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, display_on, x, y, next_frame, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus sync/active flags evaluated on the next count,
// so the parent can register them in the same stage as the count itself.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  output coord_t count,
  output logic   wrap,
  output logic   sync_nxt,
  output logic   active_nxt
);

  localparam int     TOTAL = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST  = coord_t'(TOTAL - 1);

  coord_t count_nxt;

  assign wrap = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (en)
      count_nxt = wrap ? '0 : count + coord_t'(1);
  end

  // int compares keep the sync end boundary exact even when it equals 2**COORD_W
  assign sync_nxt   = (int'(count_nxt) >= ACTIVE + FP) && (int'(count_nxt) < ACTIVE + FP + SYNC);
  assign active_nxt = (int'(count_nxt) < ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: x/y counters with syncs, display_on and frame strobe
// all registered in one stage so every output describes the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);

  localparam int     H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t V_LAST_ACTIVE = coord_t'(V_ACTIVE - 1);

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end
  endgenerate

  coord_t     h_count, v_count;
  logic       h_wrap, v_wrap_unused;
  logic       h_sync_nxt, v_sync_nxt;
  logic       h_act_nxt, v_act_nxt;
  logic       v_en, frame_start;
  logic       hsync_q, vsync_q, display_on_q, next_frame_q;
  logic [7:0] frame_count_q;

  assign v_en        = h_wrap & vga.pix_en;
  assign frame_start = v_en && (v_count == V_LAST_ACTIVE);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (vga.pix_en),
    .clr        (1'b0),
    .count      (h_count),
    .wrap       (h_wrap),
    .sync_nxt   (h_sync_nxt),
    .active_nxt (h_act_nxt)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (v_en),
    .clr        (1'b0),
    .count      (v_count),
    .wrap       (v_wrap_unused),
    .sync_nxt   (v_sync_nxt),
    .active_nxt (v_act_nxt)
  );

  // With pix_en low the next-state flags equal the current ones, so these hold naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b1;
      next_frame_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hsync_q      <= ~h_sync_nxt;
      vsync_q      <= ~v_sync_nxt;
      display_on_q <= h_act_nxt & v_act_nxt;
      next_frame_q <= frame_start;
      if (frame_start)
        frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vga.x           = h_count;
  assign vga.y           = v_count;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.next_frame  = next_frame_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance for line timing, shrunken instance (15x8 raster) for
// frame-level behaviour, strobed enable, frame counter wrap and mid-frame reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  // small raster: H 8/2/3/2 -> 15, V 4/1/2/1 -> 8, frame = 120 enabled cycles
  localparam int SH_A = 8, SH_FP = 2, SH_S = 3, SH_BP = 2;
  localparam int SV_A = 4, SV_FP = 1, SV_S = 2, SV_BP = 1;

  logic clk = 1'b0;
  logic rst_n, rst_n_d;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if s_if ();
  vga_timing_gen_if d_if ();

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (s_if.master)
  );

  vga_timing_gen u_full (
    .clk   (clk),
    .rst_n (rst_n_d),
    .vga   (d_if.master)
  );

  typedef struct {
    int   ncyc;
    logic en;
    int   ex;
    int   ey;
    logic hs;
    logic vs;
    logic de;
    logic nf;
    int   fc;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int ex, input int ey, input logic hs, input logic vs,
                                     input logic de, input logic nf, input int fc);
    return {ex[9:0], ey[9:0], hs, vs, de, nf, fc[7:0]};
  endfunction

  function automatic logic [31:0] snap();
    return {s_if.x, s_if.y, s_if.hsync, s_if.vsync, s_if.display_on, s_if.next_frame,
            s_if.frame_count};
  endfunction

  initial begin
    int ex, ey, efc, hs_low, hs_first, hs_last, de_fall, nf_seen, t_first, t_second, cyc;
    logic prev_de, exp_nf;

    rst_n     = 1'b0;
    rst_n_d   = 1'b0;
    s_if.pix_en = 1'b1;
    d_if.pix_en = 1'b1;
    tick();
    tick();
    check("reset_small", snap(), pk(0, 0, 1, 1, 1, 0, 0));
    check("reset_full", {d_if.x, d_if.y, d_if.hsync, d_if.vsync, d_if.display_on,
                         d_if.next_frame, d_if.frame_count}, pk(0, 0, 1, 1, 1, 0, 0));

    // full-size line: hsync window and display_on fall over 800 cycles
    rst_n_d  = 1'b1;
    hs_low   = 0;
    hs_first = -1;
    hs_last  = -1;
    de_fall  = -1;
    prev_de  = d_if.display_on;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (!d_if.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_if.x);
        hs_last = int'(d_if.x);
      end
      if (prev_de && !d_if.display_on) de_fall = int'(d_if.x);
      prev_de = d_if.display_on;
    end
    check("full_hsync_width", 32'(hs_low), 32'd96);
    check("full_hsync_first_x", 32'(hs_first), 32'd656);
    check("full_hsync_last_x", 32'(hs_last), 32'd751);
    check("full_de_fall_x", 32'(de_fall), 32'd640);
    check("full_line_wrap_xy", {12'd0, d_if.x, d_if.y}, {12'd0, 10'd0, 10'd1});
    rst_n_d = 1'b0;

    //            ncyc en  x   y  hs  vs  de  nf  fc
    vecs[0]  = '{ 1, 1'b1,  1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[1]  = '{ 7, 1'b1,  8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{ 2, 1'b1, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{ 2, 1'b0, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{ 2, 1'b1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{ 1, 1'b1, 13, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{ 1, 1'b1, 14, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[7]  = '{ 1, 1'b1,  0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[8]  = '{44, 1'b1, 14, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{ 1, 1'b1,  0, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{ 1, 1'b1,  1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[11] = '{14, 1'b1,  0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{15, 1'b1,  0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{15, 1'b1,  0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[14] = '{14, 1'b1, 14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vecs[15] = '{ 1, 1'b1,  0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1};

    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      s_if.pix_en = vecs[v].en;
      for (int c = 0; c < vecs[v].ncyc; c++) tick();
      check($sformatf("vec%0d", v), snap(),
            pk(vecs[v].ex, vecs[v].ey, vecs[v].hs, vecs[v].vs, vecs[v].de, vecs[v].nf, vecs[v].fc));
    end
    s_if.pix_en = 1'b1;

    // one complete frame, every pixel checked against the raster formulas
    ex  = 0;
    ey  = 0;
    efc = 1;
    for (int i = 0; i < 120; i++) begin
      ex++;
      if (ex == 15) begin
        ex = 0;
        ey++;
        if (ey == 8) ey = 0;
      end
      exp_nf = (ex == 0) && (ey == SV_A);
      if (exp_nf) efc++;
      tick();
      check($sformatf("scan_%0d_%0d", ex, ey), snap(),
            pk(ex, ey, !(ex >= 10 && ex < 13), !(ey >= 5 && ey < 7),
               (ex < SH_A) && (ey < SV_A), exp_nf, efc));
    end

    // strobed enable: pix_en high on alternate clocks, 480 clocks = 2 frames
    nf_seen  = 0;
    t_first  = -1;
    t_second = -1;
    s_if.pix_en = 1'b1;
    for (int i = 1; i <= 480; i++) begin
      tick();
      s_if.pix_en = ~s_if.pix_en;
      if (i == 1) check("strobe_x_after_1", {22'd0, s_if.x}, 32'd1);
      if (i == 2) check("strobe_x_after_2", {22'd0, s_if.x}, 32'd1);
      if (s_if.next_frame) begin
        nf_seen++;
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
    end
    check("strobe_nf_clks", 32'(nf_seen), 32'd2);
    check("strobe_nf_first", 32'(t_first), 32'd119);
    check("strobe_period", 32'(t_second - t_first), 32'd240);
    check("strobe_end", snap(), pk(0, 0, 1, 1, 1, 0, 4));

    // frame counter wrap 255 -> 0
    s_if.pix_en = 1'b1;
    for (int i = 0; i < 251 * 120; i++) tick();
    check("fc_255", snap(), pk(0, 0, 1, 1, 1, 0, 255));
    for (int i = 0; i < 60; i++) tick();
    check("fc_wrap", snap(), pk(0, 4, 1, 1, 0, 1, 0));

    // asynchronous reset mid-frame, between clock edges
    for (int i = 0; i < 20; i++) tick();
    check("pre_reset_pos", snap(), pk(5, 5, 1, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", snap(), pk(0, 0, 1, 1, 1, 0, 0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_first", snap(), pk(1, 0, 1, 1, 1, 0, 0));
    nf_seen = 0;
    cyc     = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      cyc++;
      if (s_if.next_frame && cyc < 59) nf_seen++;
    end
    check("post_reset_no_early_nf", 32'(nf_seen), 32'd0);
    check("post_reset_frame", snap(), pk(0, 4, 1, 1, 0, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
